// File: rtl/leg_pkg.sv
// ============================================================================
// Module      : leg_pkg
// Description : Shared types and constants for the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package leg_pkg;

  // Arbiter ownership state: nobody holds the bus, or exactly one channel does
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Width of the per-transfer write-width code
  localparam int MEM_WIDTH_W = 3;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Round-robin picker. Returns the first requesting channel at
//               or after the pointer, wrapping from NUM_CH-1 back to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]         i_req,
  input  logic [$clog2(NUM_CH)-1:0] i_ptr,
  output logic [NUM_CH-1:0]         o_win,
  output logic                      o_valid
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] w_sum;
  logic [IDX_W-1:0] w_pos;

  // Scan channels in priority order starting at the pointer; first hit wins
  always_comb begin
    o_win   = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sum = {1'b0, i_ptr} + SUM_W'(i);
      if (w_sum >= SUM_W'(NUM_CH)) begin
        w_sum = w_sum - SUM_W'(NUM_CH);
      end
      w_pos = w_sum[IDX_W-1:0];
      if (!o_valid && i_req[w_pos]) begin
        o_win[w_pos] = 1'b1;
        o_valid      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter granting one of NUM_CH channels ownership
//               of a single memory port. The owner's handshakes pass through
//               combinationally; ownership lasts until the owner drops its
//               request.
//               Optional feature macro MEM_ARB_WATCHDOG_EN: revokes a grant
//               that goes WDOG_CYCLES owned cycles without a handshake and
//               pulses o_timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_arbiter
  import leg_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = `DATA_WIDTH,
  parameter int WDOG_CYCLES = 256
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  // channel side
  input  logic [NUM_CH-1:0]             i_ch_req,
  input  logic [NUM_CH*ADDR_W-1:0]      i_ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]      i_ch_data,
  input  logic [NUM_CH-1:0]             i_ch_wr_valid,
  input  logic [NUM_CH*MEM_WIDTH_W-1:0] i_ch_wr_width,
  output logic [NUM_CH-1:0]             o_ch_wr_ready,
  output logic [DATA_W-1:0]             o_ch_data,
  output logic [NUM_CH-1:0]             o_ch_rd_valid,
  input  logic [NUM_CH-1:0]             i_ch_rd_ready,
  output logic [NUM_CH-1:0]             o_ch_grant,
  // memory side
  output logic [ADDR_W-1:0]             o_addr,
  output logic [DATA_W-1:0]             o_data,
  output logic                          o_wr_valid,
  input  logic                          i_wr_ready,
  output logic [MEM_WIDTH_W-1:0]        o_wr_width,
  input  logic [DATA_W-1:0]             i_data,
  input  logic                          i_rd_valid,
  output logic                          o_rd_ready,
  output logic                          o_timeout
);

  localparam int IDX_W = $clog2(NUM_CH);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  logic [NUM_CH-1:0] r_grant;
  logic [NUM_CH-1:0] w_grant_next;
  logic [IDX_W-1:0]  r_owner;
  logic [IDX_W-1:0]  w_owner_next;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  w_rr_ptr_next;

  logic [NUM_CH-1:0] w_cand;
  logic [NUM_CH-1:0] w_win;
  logic              w_win_valid;
  logic [IDX_W-1:0]  w_win_idx;
  logic [IDX_W-1:0]  w_win_ptr;
  logic              w_release;
  logic              w_pick;
  logic              w_handshake;
  logic              w_wdog_fire;

  // Candidates: the current owner never competes in the cycle it lets go,
  // so a same-cycle re-request lands at lowest round-robin priority
  always_comb begin
    w_cand = i_ch_req;
    if (r_state == OWN) begin
      w_cand[r_owner] = 1'b0;
    end
  end

  rr_pick #(
    .NUM_CH (NUM_CH)
  ) u_rr_pick (
    .i_req   (w_cand),
    .i_ptr   (r_rr_ptr),
    .o_win   (w_win),
    .o_valid (w_win_valid)
  );

  // Encode the one-hot winner and compute the pointer slot just past it
  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_win[i]) begin
        w_win_idx = IDX_W'(i);
      end
    end
    if (w_win_idx == IDX_W'(NUM_CH - 1)) begin
      w_win_ptr = '0;
    end else begin
      w_win_ptr = w_win_idx + IDX_W'(1);
    end
  end

  assign w_handshake = (o_wr_valid && i_wr_ready) || (i_rd_valid && o_rd_ready);
  assign w_release   = (r_state == OWN) && (!i_ch_req[r_owner] || w_wdog_fire);
  assign w_pick      = (r_state == IDLE) || w_release;

  // Next-state: arbitrate when idle or when the owner lets go / is revoked
  always_comb begin
    w_state_next  = r_state;
    w_grant_next  = r_grant;
    w_owner_next  = r_owner;
    w_rr_ptr_next = r_rr_ptr;
    if (w_pick) begin
      if (w_win_valid) begin
        w_state_next  = OWN;
        w_grant_next  = w_win;
        w_owner_next  = w_win_idx;
        w_rr_ptr_next = w_win_ptr;
      end else begin
        w_state_next = IDLE;
        w_grant_next = '0;
      end
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_next;
      r_grant  <= w_grant_next;
      r_owner  <= w_owner_next;
      r_rr_ptr <= w_rr_ptr_next;
    end
  end

  assign o_ch_grant = r_grant;

  // Zero-latency steering between the owner and the memory port
  always_comb begin
    o_addr        = '0;
    o_data        = '0;
    o_wr_valid    = 1'b0;
    o_wr_width    = '0;
    o_rd_ready    = 1'b0;
    o_ch_wr_ready = '0;
    o_ch_rd_valid = '0;
    o_ch_data     = i_data;
    if (r_state == OWN) begin
      o_addr                 = i_ch_addr[r_owner*ADDR_W +: ADDR_W];
      o_data                 = i_ch_data[r_owner*DATA_W +: DATA_W];
      o_wr_valid             = i_ch_wr_valid[r_owner];
      o_wr_width             = i_ch_wr_width[r_owner*MEM_WIDTH_W +: MEM_WIDTH_W];
      o_rd_ready             = i_ch_rd_ready[r_owner];
      o_ch_wr_ready[r_owner] = i_wr_ready;
      o_ch_rd_valid[r_owner] = i_rd_valid;
    end
  end

`ifdef MEM_ARB_WATCHDOG_EN
  // Counter holds 0..WDOG_CYCLES-1; it fires on the last stalled owned cycle
  localparam int CNT_W = $clog2(WDOG_CYCLES);

  logic [CNT_W-1:0] r_wdog_cnt;
  logic             r_timeout;

  assign w_wdog_fire = (r_state == OWN) && !w_handshake &&
                       (r_wdog_cnt == CNT_W'(WDOG_CYCLES - 1));

  // Count stalled owned cycles; any handshake or ownership change restarts it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wdog_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_wdog_fire;
      if ((r_state != OWN) || w_handshake || w_pick) begin
        r_wdog_cnt <= '0;
      end else begin
        r_wdog_cnt <= r_wdog_cnt + CNT_W'(1);
      end
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_wdog_fire = 1'b0;
  assign o_timeout   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter (NUM_CH=4). Directed
//               per-cycle vectors plus hand-written multi-cycle sequences.
//               The watchdog sequence is built only with MEM_ARB_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic               i_clk;
  logic               i_rst_n;
  logic [NCH-1:0]     i_ch_req;
  logic [NCH*AW-1:0]  i_ch_addr;
  logic [NCH*DW-1:0]  i_ch_data;
  logic [NCH-1:0]     i_ch_wr_valid;
  logic [NCH*3-1:0]   i_ch_wr_width;
  logic [NCH-1:0]     o_ch_wr_ready;
  logic [DW-1:0]      o_ch_data;
  logic [NCH-1:0]     o_ch_rd_valid;
  logic [NCH-1:0]     i_ch_rd_ready;
  logic [NCH-1:0]     o_ch_grant;
  logic [AW-1:0]      o_addr;
  logic [DW-1:0]      o_data;
  logic               o_wr_valid;
  logic               i_wr_ready;
  logic [2:0]         o_wr_width;
  logic [DW-1:0]      i_data;
  logic               i_rd_valid;
  logic               o_rd_ready;
  logic               o_timeout;

  mem_arbiter #(
    .NUM_CH      (NCH),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .WDOG_CYCLES (8)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_ch_req      (i_ch_req),
    .i_ch_addr     (i_ch_addr),
    .i_ch_data     (i_ch_data),
    .i_ch_wr_valid (i_ch_wr_valid),
    .i_ch_wr_width (i_ch_wr_width),
    .o_ch_wr_ready (o_ch_wr_ready),
    .o_ch_data     (o_ch_data),
    .o_ch_rd_valid (o_ch_rd_valid),
    .i_ch_rd_ready (i_ch_rd_ready),
    .o_ch_grant    (o_ch_grant),
    .o_addr        (o_addr),
    .o_data        (o_data),
    .o_wr_valid    (o_wr_valid),
    .i_wr_ready    (i_wr_ready),
    .o_wr_width    (o_wr_width),
    .i_data        (i_data),
    .i_rd_valid    (i_rd_valid),
    .o_rd_ready    (o_rd_ready),
    .o_timeout     (o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Fixed per-channel payloads
  logic [31:0] c_addr  [NCH];
  logic [31:0] c_data  [NCH];
  logic [2:0]  c_width [NCH];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  wv;
    logic [3:0]  rr;
    logic        wrdy;
    logic        rvld;
    logic [31:0] idata;
    logic [3:0]  eg;
    logic        eowv;
    logic        erdy;
    logic [3:0]  ecwr;
    logic [3:0]  ecrv;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick32(input logic [3:0] g, input logic [31:0] arr [NCH]);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) if (g[i]) r = arr[i];
    return r;
  endfunction

  function automatic logic [2:0] pickw(input logic [3:0] g);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) if (g[i]) r = c_width[i];
    return r;
  endfunction

  task automatic clear_inputs();
    i_ch_req      = '0;
    i_ch_wr_valid = '0;
    i_ch_rd_ready = '0;
    i_wr_ready    = 1'b0;
    i_rd_valid    = 1'b0;
    i_data        = '0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wv_cycles;
    int own0;
    int own1;
    int tcount;
    int t_on_switch;
    logic [3:0] ord [5];

    c_addr  = '{32'h0000_0040, 32'h0000_0100, 32'h0000_0200, 32'h0000_0300};
    c_data  = '{32'h1111_1111, 32'hDEAD_BEEF, 32'h3333_3333, 32'h4444_4444};
    c_width = '{3'd1, 3'd2, 3'd3, 3'd4};
    for (int i = 0; i < NCH; i++) begin
      i_ch_addr[i*AW +: AW] = c_addr[i];
      i_ch_data[i*DW +: DW] = c_data[i];
      i_ch_wr_width[i*3 +: 3] = c_width[i];
    end

    //            req      wv       rr       wrdy  rvld  idata           eg       eowv  erdy  ecwr     ecrv
    vecs[0]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,         4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b0011, 4'b1111, 4'b1111, 1'b1, 1'b1, 32'hCAFEF00D,  4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000};
    vecs[2]  = '{4'b0011, 4'b0000, 4'b0011, 1'b0, 1'b1, 32'h12345678,  4'b0001, 1'b0, 1'b1, 4'b0000, 4'b0001};
    vecs[3]  = '{4'b0010, 4'b0011, 4'b0000, 1'b0, 1'b0, 32'h0,         4'b0001, 1'b1, 1'b0, 4'b0000, 4'b0000};
    vecs[4]  = '{4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b0, 32'h0,         4'b0010, 1'b1, 1'b0, 4'b0010, 4'b0000};
    vecs[5]  = '{4'b0010, 4'b0001, 4'b0001, 1'b1, 1'b1, 32'h55AA55AA,  4'b0010, 1'b0, 1'b0, 4'b0010, 4'b0010};
    vecs[6]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,         4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0000};
    vecs[7]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 32'h0F0F0F0F,  4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000};
    vecs[8]  = '{4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,         4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000};
    vecs[9]  = '{4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,         4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000};
    vecs[10] = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,         4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000};
    vecs[11] = '{4'b1001, 4'b0000, 4'b0001, 1'b0, 1'b0, 32'h0,         4'b0001, 1'b0, 1'b1, 4'b0000, 4'b0000};
    vecs[12] = '{4'b1001, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,         4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0000};
    vecs[13] = '{4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,         4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0000};
    vecs[14] = '{4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b0, 32'h0,         4'b1000, 1'b1, 1'b0, 4'b1000, 4'b0000};
    vecs[15] = '{4'b0011, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,         4'b1000, 1'b0, 1'b0, 4'b0000, 4'b0000};
    vecs[16] = '{4'b1011, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,         4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0000};

    ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    i_rst_n = 1'b0;
    clear_inputs();
    #1;
    check("reset_grant", 64'(o_ch_grant), 64'h0);
    check("reset_wr_valid", 64'(o_wr_valid), 64'h0);
    check("reset_timeout", 64'(o_timeout), 64'h0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;

    // Per-cycle directed vectors
    for (int v = 0; v < 17; v++) begin
      @(negedge i_clk);
      i_ch_req      = vecs[v].req;
      i_ch_wr_valid = vecs[v].wv;
      i_ch_rd_ready = vecs[v].rr;
      i_wr_ready    = vecs[v].wrdy;
      i_rd_valid    = vecs[v].rvld;
      i_data        = vecs[v].idata;
      #1;
      check($sformatf("v%0d_grant", v), 64'(o_ch_grant), 64'(vecs[v].eg));
      check($sformatf("v%0d_wr_valid", v), 64'(o_wr_valid), 64'(vecs[v].eowv));
      check($sformatf("v%0d_rd_ready", v), 64'(o_rd_ready), 64'(vecs[v].erdy));
      check($sformatf("v%0d_ch_wr_ready", v), 64'(o_ch_wr_ready), 64'(vecs[v].ecwr));
      check($sformatf("v%0d_ch_rd_valid", v), 64'(o_ch_rd_valid), 64'(vecs[v].ecrv));
      check($sformatf("v%0d_ch_data", v), 64'(o_ch_data), 64'(vecs[v].idata));
      check($sformatf("v%0d_addr", v), 64'(o_addr), 64'(pick32(vecs[v].eg, c_addr)));
      check($sformatf("v%0d_data", v), 64'(o_data), 64'(pick32(vecs[v].eg, c_data)));
      check($sformatf("v%0d_wr_width", v), 64'(o_wr_width), 64'(pickw(vecs[v].eg)));
      check($sformatf("v%0d_timeout", v), 64'(o_timeout), 64'h0);
    end

    // Stalled write on ch1: valid held 4 cycles, ready passes through same cycle
    do_reset();
    i_ch_req = 4'b0010;
    @(negedge i_clk);
    #1;
    check("wr_grant_ch1", 64'(o_ch_grant), 64'h2);
    i_ch_wr_valid = 4'b0010;
    wv_cycles = 0;
    for (int c = 0; c < 4; c++) begin
      i_wr_ready = (c == 3);
      #1;
      if (o_wr_valid) wv_cycles++;
      check($sformatf("wr_c%0d_ch_wr_ready", c), 64'(o_ch_wr_ready), (c == 3) ? 64'h2 : 64'h0);
      check($sformatf("wr_c%0d_addr", c), 64'(o_addr), 64'h100);
      check($sformatf("wr_c%0d_data", c), 64'(o_data), 64'hDEADBEEF);
      @(negedge i_clk);
    end
    i_ch_wr_valid = 4'b0000;
    i_wr_ready    = 1'b0;
    #1;
    check("wr_valid_cycles", 64'(wv_cycles), 64'd4);
    check("wr_valid_after", 64'(o_wr_valid), 64'h0);

    // Reset in the middle of a second write
    i_ch_wr_valid = 4'b0010;
    #1;
    check("midwr_valid_before", 64'(o_wr_valid), 64'h1);
    i_rst_n = 1'b0;
    #1;
    check("midwr_rst_grant", 64'(o_ch_grant), 64'h0);
    check("midwr_rst_wr_valid", 64'(o_wr_valid), 64'h0);
    check("midwr_rst_addr", 64'(o_addr), 64'h0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n       = 1'b1;
    i_ch_req      = 4'b0000;
    i_ch_wr_valid = 4'b1111;
    i_ch_rd_ready = 4'b1111;
    i_wr_ready    = 1'b1;
    i_rd_valid    = 1'b1;
    #1;
    check("rel_ch_wr_ready", 64'(o_ch_wr_ready), 64'h0);
    check("rel_ch_rd_valid", 64'(o_ch_rd_valid), 64'h0);
    @(negedge i_clk);
    #1;
    check("rel1_ch_wr_ready", 64'(o_ch_wr_ready), 64'h0);
    check("rel1_wr_valid", 64'(o_wr_valid), 64'h0);
    clear_inputs();

    // All channels requesting; rr pointer restarted at 0 picks ch0 first
    i_ch_req = 4'b1111;
    @(negedge i_clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr_order_%0d", k), 64'(o_ch_grant), 64'(ord[k]));
      i_ch_rd_ready = ord[k];
      i_rd_valid    = 1'b1;
      i_data        = 32'hA000_0000 + 32'(k);
      #1;
      check($sformatf("rr_rd_valid_%0d", k), 64'(o_ch_rd_valid), 64'(ord[k]));
      @(negedge i_clk);
      i_rd_valid    = 1'b0;
      i_ch_rd_ready = 4'b0000;
      i_ch_req      = 4'b1111 & ~ord[k];
      @(negedge i_clk);
      i_ch_req = 4'b1111;
      #1;
    end

`ifdef MEM_ARB_WATCHDOG_EN
    // Owner ch0 stalls; after 8 owned cycles the grant moves to pending ch1
    do_reset();
    i_ch_req = 4'b0011;
    own0 = 0;
    own1 = 0;
    tcount = 0;
    t_on_switch = 0;
    @(negedge i_clk);
    for (int c = 0; c < 12; c++) begin
      #1;
      if (o_ch_grant == 4'b0001) own0++;
      if (o_ch_grant == 4'b0010) begin
        if (own1 == 0 && o_timeout) t_on_switch = 1;
        own1++;
      end
      if (o_timeout) tcount++;
      @(negedge i_clk);
    end
    check("wdog_owner_cycles", 64'(own0), 64'd8);
    check("wdog_next_cycles", 64'(own1), 64'd4);
    check("wdog_timeout_pulses", 64'(tcount), 64'd1);
    check("wdog_timeout_on_switch", 64'(t_on_switch), 64'd1);
`else
    own0 = 0;
    own1 = 0;
    tcount = 0;
    t_on_switch = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
